div_seq: RTL
============

// Module: div_seq
// PURPOSE
//  Multi-cycle iterative divider sequencer for the LoongArch32 EX stage. Executes div.w/mod.w/div.wu/mod.wu.
//  Runs a radix-2 restoring algorithm, one trial subtraction per cycle.
//  Sits beside the single-cycle ALU. EX stalls on div_ready/res_valid until the quotient or remainder is returned.
// PARAMETERS
//  DATA_W   32            operand/result width; iteration count equals DATA_W
//  DIVZ_Q   32'hFFFFFFFF  quotient returned for divide-by-zero (signed and unsigned)
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  resetn      in   1       synchronous, active-low reset
//  div_valid   in   1       request present
//  div_ready   out  1       block can accept a request (high only in IDLE)
//  div_signed  in   1       1 = div.w/mod.w, 0 = div.wu/mod.wu
//  div_mod     in   1       1 = return remainder, 0 = return quotient
//  div_src1    in   DATA_W  dividend (rj)
//  div_src2    in   DATA_W  divisor (rk)
//  div_flush   in   1       pipeline flush (exception/branch); kills any operation
//  res_valid   out  1       result valid; held until res_ready
//  res_ready   in   1       consumer takes result
//  res_data    out  DATA_W  quotient or remainder
// BEHAVIOUR
//  Reset (resetn=0 at edge): state=IDLE, div_ready=1, res_valid=0, res_data=0, count=0. Overrides everything.
//  FSM states: IDLE, ITER, SIGN, DONE.
//  IDLE: div_valid&div_ready accepts at edge E0.
//    Latches |src1| and |src2|: two's-complement abs when div_signed, else raw.
//    Latches the quotient sign (s1^s2) and remainder sign (s1), both forced 0 when unsigned.
//    Latches div_mod; rem<=0, count<=0; -> ITER.
//  ITER: each edge computes rem'={rem[DATA_W-1:0],dvd[MSB]} (DATA_W+1 bits) and trial=rem'-{1'b0,dvs}.
//    No borrow: rem<=trial, qbit=1. Borrow: rem<=rem', qbit=0.
//    dvd<={dvd<<1,qbit}, so the quotient is built in dvd. count++.
//    After DATA_W iterations (edge E32) -> SIGN.
//  SIGN (edge E33): negate quotient if qsign, negate remainder if rsign.
//    Select by div_mod into res_data; res_valid<=1; -> DONE.
//    Latency: res_valid first visible in the cycle after E33, i.e. 33 cycles after acceptance.
//  DONE: res_valid=1 and res_data stable until res_valid&res_ready; then res_valid<=0, -> IDLE.
//    div_ready rises the following cycle; no back-to-back acceptance from DONE.
//  Divide by zero: quotient=DIVZ_Q, remainder=div_src1 (original, unsigned-sign-corrected value), no trap.
//    The natural datapath result is overridden in SIGN.
//  Overflow (signed 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. No special case needed; must hold.
//  Arithmetic: abs/negate are modulo 2^DATA_W; the internal remainder is DATA_W+1 bits, so no carry is lost.
//  div_flush=1 at any edge: -> IDLE, res_valid<=0, result discarded.
//    Flush wins over a same-cycle accept (no request latched) and over a same-cycle res_ready.
//  div_ready is combinational from state only (not from div_valid). Inputs are ignored outside IDLE.
//  Signals other than res_valid/res_data/div_ready have no external visibility; res_data is don't-care when res_valid=0.
// STRUCTURE
//  Shared package mycpu_pkg:
//    DIV_IDLE/DIV_ITER/DIV_SIGN/DIV_DONE state encodings.
//    ALU_OP_* one-hot constants (bit0 add .. bit11 lui) used by the decoder for ALU and divider dispatch.
//  Sub-module div_step: combinational one-iteration compare/subtract (inputs rem, dvd MSB, dvs).
//    Outputs new rem and qbit. Instantiated once; div_seq holds all registers and the FSM.
// TESTING
//  1 unsigned: src1=100, src2=7, signed=0, mod=0 -> res_data=14 exactly 33 cycles after accept; mod=1 -> 2.
//  2 signed signs: -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
//    7/-2 -> q=-3, r=1.
//    -7/-2 -> q=3, r=-1.
//  3 corners: 0x80000000/0xFFFFFFFF signed -> q=0x80000000, r=0.
//    Unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF.
//    x/0 -> q=0xFFFFFFFF, r=x.
//  4 handshake: hold res_ready=0 for 10 cycles -> res_valid/res_data stable.
//    Release -> res_valid drops next edge, div_ready=1 one cycle later; div_valid in DONE is not accepted.
//  5 flush: assert div_flush at ITER count=15 -> IDLE next edge, no res_valid.
//    Assert div_flush with div_valid in IDLE -> nothing accepted.
//  6 reset: resetn=0 for one edge mid-ITER -> div_ready=1, res_valid=0, res_data=0.
//    A subsequent 100/7 request completes correctly.

Source files
------------

// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mycpu_pkg
// Purpose : Shared CPU definitions. Divider sequencer state encodings and
//           one-hot ALU operation codes used by the decoder to dispatch work
//           to the single-cycle ALU or the iterative divider.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mycpu_pkg;

  // Divider sequencer states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_SIGN = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // One-hot ALU operation codes (bit0 add .. bit11 lui)
  localparam int          ALU_OP_W    = 12;
  localparam logic [11:0] ALU_OP_ADD  = 12'h001;
  localparam logic [11:0] ALU_OP_SUB  = 12'h002;
  localparam logic [11:0] ALU_OP_SLT  = 12'h004;
  localparam logic [11:0] ALU_OP_SLTU = 12'h008;
  localparam logic [11:0] ALU_OP_AND  = 12'h010;
  localparam logic [11:0] ALU_OP_NOR  = 12'h020;
  localparam logic [11:0] ALU_OP_OR   = 12'h040;
  localparam logic [11:0] ALU_OP_XOR  = 12'h080;
  localparam logic [11:0] ALU_OP_SLL  = 12'h100;
  localparam logic [11:0] ALU_OP_SRL  = 12'h200;
  localparam logic [11:0] ALU_OP_SRA  = 12'h400;
  localparam logic [11:0] ALU_OP_LUI  = 12'h800;

endpackage : mycpu_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Purpose : One iteration of a radix-2 restoring divider. Shifts the next
//           dividend bit into the partial remainder and performs a trial
//           subtraction of the divisor; keeps the difference when it does
//           not borrow.
// Ports   : rem_i      in  DATA_W+1  current partial remainder
//           dvd_msb_i  in  1         next dividend bit to shift in
//           dvs_i      in  DATA_W    divisor (magnitude)
//           rem_o      out DATA_W+1  updated partial remainder
//           qbit_o     out 1         quotient bit produced this step
// Rev     : 1.0  initial release
// ============================================================================
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_i,
  input  logic              dvd_msb_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W:0]   rem_o,
  output logic              qbit_o
);

  // The partial remainder is always below the divisor, so its top bit is
  // zero and the shifted value fits in DATA_W+1 bits. Working one bit wider
  // lets the trial difference's top bit act as the borrow flag.
  logic [DATA_W+1:0] w_shift;
  logic [DATA_W+1:0] w_trial;

  always_comb begin
    w_shift = {rem_i, dvd_msb_i};
    w_trial = w_shift - {2'b00, dvs_i};
    qbit_o  = ~w_trial[DATA_W+1];
    rem_o   = qbit_o ? w_trial[DATA_W:0] : w_shift[DATA_W:0];
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module  : div_seq
// Purpose : Multi-cycle iterative divider for the EX stage (div.w, mod.w,
//           div.wu, mod.wu). Operand magnitudes are divided with one
//           restoring step per cycle, then signs are applied. Result is
//           valid 33 cycles after acceptance and held until consumed.
// Ports   : clk        in  1       clock, rising edge
//           resetn     in  1       synchronous active-low reset
//           div_valid  in  1       request present
//           div_ready  out 1       can accept (IDLE only)
//           div_signed in  1       1 = signed op
//           div_mod    in  1       1 = remainder, 0 = quotient
//           div_src1   in  DATA_W  dividend
//           div_src2   in  DATA_W  divisor
//           div_flush  in  1       kill any operation
//           res_valid  out 1       result valid, held until res_ready
//           res_ready  in  1       consumer takes result
//           res_data   out DATA_W  quotient or remainder
// Rev     : 1.0  initial release
// ============================================================================
module div_seq
  import mycpu_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] DIVZ_Q = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic              div_signed,
  input  logic              div_mod,
  input  logic [DATA_W-1:0] div_src1,
  input  logic [DATA_W-1:0] div_src2,
  input  logic              div_flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;       // dividend magnitude, becomes quotient
  logic [DATA_W-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [DATA_W:0]   rem_q, rem_d;       // partial remainder
  logic [CNT_W-1:0]  count_q, count_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic              mod_q, mod_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

  logic [DATA_W:0]   w_step_rem;
  logic              w_step_qbit;
  logic              w_s1_neg;
  logic              w_s2_neg;
  logic [DATA_W-1:0] w_q_fix;
  logic [DATA_W-1:0] w_r_fix;

  div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[DATA_W-1]),
    .dvs_i     (dvs_q),
    .rem_o     (w_step_rem),
    .qbit_o    (w_step_qbit)
  );

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    count_d     = count_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    mod_d       = mod_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    div_ready   = (state_q == DIV_IDLE);
    w_s1_neg    = div_signed & div_src1[DATA_W-1];
    w_s2_neg    = div_signed & div_src2[DATA_W-1];

    // Sign correction of the unsigned result. A zero divisor leaves the
    // remainder equal to |src1| (no subtraction ever borrows), so only the
    // quotient needs overriding.
    w_q_fix = qsign_q ? (~dvd_q + 1'b1) : dvd_q;
    if (dvs_q == '0) begin
      w_q_fix = DIVZ_Q;
    end
    w_r_fix = rsign_q ? (~rem_q[DATA_W-1:0] + 1'b1) : rem_q[DATA_W-1:0];

    case (state_q)
      DIV_IDLE: begin
        if (div_valid && !div_flush) begin
          dvd_d   = w_s1_neg ? (~div_src1 + 1'b1) : div_src1;
          dvs_d   = w_s2_neg ? (~div_src2 + 1'b1) : div_src2;
          qsign_d = w_s1_neg ^ w_s2_neg;
          rsign_d = w_s1_neg;
          mod_d   = div_mod;
          rem_d   = '0;
          count_d = '0;
          state_d = DIV_ITER;
        end
      end
      DIV_ITER: begin
        dvd_d   = {dvd_q[DATA_W-2:0], w_step_qbit};
        rem_d   = w_step_rem;
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = DIV_SIGN;
        end
      end
      DIV_SIGN: begin
        res_data_d  = mod_q ? w_r_fix : w_q_fix;
        res_valid_d = 1'b1;
        state_d     = DIV_DONE;
      end
      DIV_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // Flush beats every other transition, including a same-cycle handshake.
    if (div_flush) begin
      res_valid_d = 1'b0;
      state_d     = DIV_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= DIV_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      mod_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      mod_q       <= mod_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule : div_seq
`default_nettype wire
